// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states and frame constants.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;
    localparam int         HDR_LEN    = 3;

    // Terminal states stop taking bytes; every other state always accepts.
    function automatic logic accepts_bytes(input boot_state_t s);
        return !(s == ST_DONE || s == ST_ERR);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction SRAM write port of the boot loader.
interface boot_loader_if #(
    parameter int AW = 12
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/boot_loader_byte2word.sv
// Little-endian 4-byte assembler; pulses a registered word on every 4th pushed byte.
module byte2word (
    input  logic        clk,
    input  logic        srst,
    input  logic        push,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_cnt,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic        r_word_valid;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cnt        <= 2'd0;
            r_shift      <= 24'd0;
            r_word_valid <= 1'b0;
            r_word       <= 32'd0;
        end else begin
            r_word_valid <= 1'b0;
            if (push) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word       <= {i_byte, r_shift};
                    r_word_valid <= 1'b1;
                end else begin
                    // Bytes enter at the top so the first one ends up in [7:0].
                    r_shift <= {i_byte, r_shift[23:8]};
                end
            end
        end
    end

    assign o_byte_cnt   = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;
endmodule

// File: rtl/boot_loader.sv
// Framed program-image loader: writes words into the instruction SRAM and holds
// the core in reset until a frame with a good checksum has been loaded.
module boot_loader
    import boot_pkg::*;
#(
    parameter int         AW    = 12,
    parameter logic [7:0] MAGIC = BOOT_MAGIC
) (
    input  logic          clk,
    input  logic          cpurst,
    boot_loader_if.slave  bus,
    output logic          core_rst,
    output logic          load_done,
    output logic          load_err
);
    localparam logic [16:0] MAX_WORDS = 17'(1) << AW;

    boot_state_t   r_state;
    logic          r_in_ready;
    logic [7:0]    r_len_lo;
    logic [15:0]   r_len;
    logic [AW:0]   r_words;
    logic [7:0]    r_xor;
    logic [AW-1:0] r_wr_addr;
    logic          r_core_rst;
    logic          r_done;
    logic          r_err;

    logic          w_accept;
    logic          w_push;
    logic [15:0]   w_len;
    logic [AW:0]   w_words_inc;
    logic [1:0]    w_byte_cnt;
    logic          w_word_valid;
    logic [31:0]   w_word;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_push      = w_accept && (r_state == ST_DATA);
    assign w_len       = {bus.in_data, r_len_lo};
    assign w_words_inc = r_words + {{AW{1'b0}}, 1'b1};

    byte2word u_byte2word (
        .clk          (clk),
        .srst         (cpurst),
        .push         (w_push),
        .i_byte       (bus.in_data),
        .o_byte_cnt   (w_byte_cnt),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_words    <= '0;
            r_xor      <= 8'd0;
            r_wr_addr  <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_ready <= accepts_bytes(r_state);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && bus.in_data == MAGIC) r_state <= ST_LEN0;
                end
                ST_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= bus.in_data;
                        r_state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if ({1'b0, w_len} > MAX_WORDS) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_xor <= r_xor ^ bus.in_data;
                        if (w_byte_cnt == 2'd3) begin
                            // Address is latched here so it lines up with the assembler's write pulse.
                            r_wr_addr <= r_words[AW-1:0];
                            r_words   <= w_words_inc;
                            if ({{(15-AW){1'b0}}, w_words_inc} == r_len) r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_xor) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_in_ready <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = w_word_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = w_word;
    assign core_rst     = r_core_rst;
    assign load_done    = r_done;
    assign load_err     = r_err;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader (AW=4): a per-cycle vector table plus frame-level sequences.
module tb_boot_loader;
    logic clk = 1'b0;
    logic cpurst = 1'b1;
    logic core_rst, load_done, load_err;

    boot_loader_if #(.AW(4)) bus ();

    boot_loader #(.AW(4), .MAGIC(8'hA5)) dut (
        .clk       (clk),
        .cpurst    (cpurst),
        .bus       (bus),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  dat;
        logic [40:0] exp; // {in_ready, wr_en, wr_addr, wr_data, core_rst, load_done, load_err}
    } vec_t;

    vec_t        vt[$];
    logic [35:0] wq[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  frame1[12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};

    always @(negedge clk) if (bus.wr_en) wq.push_back({bus.wr_addr, bus.wr_data});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic rst, input logic vld, input logic [7:0] dat,
                       input logic rdy, input logic we, input logic [3:0] addr,
                       input logic [31:0] data, input logic crst, input logic done,
                       input logic err);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat;
        v.exp = {rdy, we, addr, data, crst, done, err};
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the byte is accepted.
    task automatic send(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 8 && !acc; k++) begin
            acc = bus.in_ready;
            @(negedge clk);
        end
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: byte %h not accepted, in_ready stuck at 0", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset(input logic clear_q);
        bus.in_valid = 1'b0;
        cpurst = 1'b1;
        @(negedge clk);
        cpurst = 1'b0;
        if (clear_q) wq.delete();
    endtask

    task automatic chk_frame1(input string nm);
        chk({nm, "_nwr"}, wq.size(), 2);
        if (wq.size() == 2) begin
            chk({nm, "_w0"}, wq[0], {4'd0, 32'h0000_0013});
            chk({nm, "_w1"}, wq[1], {4'd1, 32'h0000_006F});
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Good frame, cycle by cycle
        add(1,0,8'h00, 0,0,0,32'h0,        1,0,0);
        add(1,0,8'h00, 0,0,0,32'h0,        1,0,0);
        add(0,0,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'hA5, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h02, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h13, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,1,0,32'h13,       1,0,0);
        add(0,1,8'h6F, 1,0,0,32'h13,       1,0,0);
        add(0,1,8'h00, 1,0,0,32'h13,       1,0,0);
        add(0,1,8'h00, 1,0,0,32'h13,       1,0,0);
        add(0,1,8'h00, 1,1,1,32'h6F,       1,0,0);
        add(0,1,8'h7C, 0,0,1,32'h6F,       0,1,0);
        add(0,1,8'hA5, 0,0,1,32'h6F,       0,1,0);
        add(0,0,8'h00, 0,0,1,32'h6F,       0,1,0);
        // Reset out of DONE, then the same frame with a bad checksum
        add(1,0,8'h00, 0,0,0,32'h0,        1,0,0);
        add(0,0,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'hA5, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h02, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h13, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,0,0,32'h0,        1,0,0);
        add(0,1,8'h00, 1,1,0,32'h13,       1,0,0);
        add(0,1,8'h6F, 1,0,0,32'h13,       1,0,0);
        add(0,1,8'h00, 1,0,0,32'h13,       1,0,0);
        add(0,1,8'h00, 1,0,0,32'h13,       1,0,0);
        add(0,1,8'h00, 1,1,1,32'h6F,       1,0,0);
        add(0,1,8'h00, 0,0,1,32'h6F,       1,0,1);
        add(0,1,8'hA5, 0,0,1,32'h6F,       1,0,1);
        add(0,0,8'h00, 0,0,1,32'h6F,       1,0,1);

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            cpurst       = vt[i].rst;
            bus.in_valid = vt[i].vld;
            bus.in_data  = vt[i].dat;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, core_rst, load_done, load_err},
                vt[i].exp);
        end

        // Garbage before the frame, single word 0xDEADBEEF
        do_reset(1'b1);
        foreach (frame1[i]) if (i < 0) send(8'h00, 0);
        send(8'h00, 0); send(8'hFF, 0); send(8'h12, 0);
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
        chk("dead_crst_before", core_rst, 1'b1);
        send(8'h22, 0);
        chk("dead_crst_fall", core_rst, 1'b0);
        chk("dead_done", load_done, 1'b1);
        chk("dead_nwr", wq.size(), 1);
        if (wq.size() == 1) chk("dead_w0", wq[0], {4'd0, 32'hDEAD_BEEF});

        // Oversized length: N=17 with AW=4
        do_reset(1'b1);
        send(8'hA5, 0); send(8'h11, 0); send(8'h00, 0);
        chk("len_err", load_err, 1'b1);
        chk("len_ready", bus.in_ready, 1'b0);
        chk("len_crst", core_rst, 1'b1);
        repeat (3) @(negedge clk);
        chk("len_nwr", wq.size(), 0);

        // Full-capacity image: N=16 words of 0x01010101
        do_reset(1'b1);
        send(8'hA5, 0); send(8'h10, 0); send(8'h00, 0);
        for (int i = 0; i < 64; i++) send(8'h01, 0);
        send(8'h00, 0);
        chk("full_done", load_done, 1'b1);
        chk("full_err", load_err, 1'b0);
        chk("full_nwr", wq.size(), 16);
        for (int i = 0; i < wq.size() && i < 16; i++)
            chk($sformatf("full_w%0d", i), wq[i], {i[3:0], 32'h0101_0101});

        // Empty image
        do_reset(1'b1);
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        chk("empty_done", load_done, 1'b1);
        chk("empty_crst", core_rst, 1'b0);
        repeat (2) @(negedge clk);
        chk("empty_nwr", wq.size(), 0);

        // First frame with random in_valid gaps
        do_reset(1'b1);
        chk("rst_crst", core_rst, 1'b1);
        chk("rst_done", load_done, 1'b0);
        foreach (frame1[i]) send(frame1[i], int'($urandom_range(0, 3)));
        chk("gap_done", load_done, 1'b1);
        chk_frame1("gap");

        // Abort after the 2nd data byte, then resend the whole frame
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) send(frame1[i], 0);
        do_reset(1'b0);
        chk("abort_crst", core_rst, 1'b1);
        repeat (3) @(negedge clk);
        chk("abort_nwr", wq.size(), 0);
        foreach (frame1[i]) send(frame1[i], 0);
        chk("abort_done", load_done, 1'b1);
        chk_frame1("abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
